// File: rtl/game_pkg.sv
// game_pkg: shared button/direction types and round-robin helpers for the button arbiter
package game_pkg;

    localparam int N_BTN = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_OFFER
    } arb_state_t;

    // First requesting index at or after ptr, wrapping; lowest distance wins because it is visited last.
    function automatic logic [1:0] rr_pick(input logic [N_BTN-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [N_BTN-1:0] onehot(input logic [1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, debounce counter and press pulse for one button (repeat under BTN_AUTOREPEAT_EN)
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip = (sync[1] != stable) && (cnt == CNT_W'(DEB_CYCLES - 1));

    // Synchronise, then accept a new level only after it has differed for DEB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync   <= {sync[0], raw};
            cnt    <= (sync[1] == stable || flip) ? '0 : cnt + 1'b1;
            stable <= flip ? sync[1] : stable;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    logic [RPT_W-1:0] rpt;
    logic             rpt_hit;

    assign rpt_hit = stable && (rpt == RPT_W'(REPEAT_CYCLES - 1));

    // Count held time; every REPEAT_CYCLES cycles of held level yields an extra press.
    always_ff @(posedge clk) begin
        if (reset || !stable) rpt <= '0;
        else rpt <= rpt_hit ? '0 : rpt + 1'b1;
    end

    // Press pulse on accepted rising level or on a repeat tick.
    always_ff @(posedge clk) begin
        press <= !reset && ((flip && sync[1]) || rpt_hit);
    end
`else
    // Press pulse only on an accepted rising level.
    always_ff @(posedge clk) begin
        press <= !reset && flip && sync[1];
    end
`endif

endmodule

// File: rtl/button_arbiter.sv
// button_arbiter: debounced four-button front end issuing one round-robin move command at a time over valid/ready; BTN_AUTOREPEAT_EN adds held-button repeat
module button_arbiter
    import game_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000000,
    parameter int CNT_W         = 20,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output dir_t             cmd_dir,
    output logic [N_BTN-1:0] cmd_onehot,
    output logic [N_BTN-1:0] pending,
    output logic             dropped
);
    logic [N_BTN-1:0] press, clr;
    arb_state_t       state, state_nx;
    logic [1:0]       ptr, pick;
    logic             grant, accept;

    if (DEB_CYCLES < 2 || ((DEB_CYCLES - 1) >> CNT_W) != 0 || REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("button_arbiter: DEB_CYCLES must fit CNT_W and periods must be at least 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W(CNT_W)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_deb (
            .clk(clk),
            .reset(reset),
            .raw(btn_raw[i]),
            .press(press[i])
        );
    end

    assign pick = rr_pick(pending, ptr);
    assign clr  = grant ? onehot(pick) : '0;

    // Grant from IDLE when enabled work is pending; leave OFFER only on handshake.
    always_comb begin
        grant    = (state == ARB_IDLE) && enable && (|pending);
        accept   = (state == ARB_OFFER) && cmd_ready;
        state_nx = grant ? ARB_OFFER : accept ? ARB_IDLE : state;
    end

    // State, pointer and registered command; an offer stays up until accepted or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            ptr        <= '0;
            cmd_valid  <= 1'b0;
            cmd_dir    <= DIR_UP;
            cmd_onehot <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                cmd_valid  <= 1'b1;
                cmd_dir    <= dir_t'(pick);
                cmd_onehot <= onehot(pick);
            end else if (accept) begin
                cmd_valid  <= 1'b0;
                cmd_onehot <= '0;
                ptr        <= cmd_dir + 2'd1;
            end
        end
    end

    // Latch presses (set beats grant-clear); a press on a still-pending button only pulses dropped.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | press;
            dropped <= |(press & pending & ~clr);
        end
    end

endmodule
